// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, FSM state type and index-width helper for imem_loadable
package imem_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {RUN, HDR, DATA} state_t;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles four little-endian stream bytes into a word, strobing on the 4th
module imem_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_strobe
);
  logic [1:0]  cnt;
  logic [23:0] sr;
  // The word is complete combinationally with the 4th byte so it can be written on that edge
  assign word = {din, sr};
  assign word_strobe = en && cnt == 2'd3;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      sr <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sr <= {din, sr[23:8]};
    end
endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: byte-stream loadable instruction memory with registered, range-checked fetch
module imem_loadable #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INSN    = imem_pkg::NOP_INSN,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_insn,
  output logic        fetch_fault,
  output logic        fetch_stall,
  input  logic        prog_start,
  input  logic        prog_byte_valid,
  input  logic [7:0]  prog_byte,
  output logic        prog_byte_ready,
  output logic        prog_done,
  output logic        prog_err
);
  import imem_pkg::*;
  localparam int AW = idx_w(DEPTH_WORDS);
  localparam logic [31:0] DEPTH = DEPTH_WORDS;
  state_t state, state_nx;
  logic [31:0] mem [0:DEPTH_WORDS-1];
  logic [AW:0] wptr;
  logic [31:0] rem, word;
  logic strobe, take, start, accept, fault;
  assign take = prog_byte_valid && prog_byte_ready;
  assign start = prog_start && state == RUN;
  assign accept = fetch_req && state == RUN;
  assign fault = |fetch_addr[1:0] || {2'b00, fetch_addr[31:2]} >= DEPTH;
  imem_byte_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clr(start),
    .en(take),
    .din(prog_byte),
    .word(word),
    .word_strobe(strobe)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else state <= state_nx;
  always_comb
    state_nx = state == RUN ? (prog_start ? HDR : RUN)
             : state == HDR ? (strobe ? (word == 32'd0 ? RUN : DATA) : HDR)
             : (strobe && rem == 32'd1 ? RUN : DATA);
  always_comb begin
    prog_byte_ready = state != RUN;
    fetch_stall = state != RUN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rem <= '0;
      prog_done <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      prog_done <= state != RUN && state_nx == RUN;
      if (start) begin
        wptr <= '0;
        prog_err <= 1'b0;
      end
      if (strobe && state == HDR) begin
        rem <= word;
        prog_err <= word > DEPTH;
      end
      if (strobe && state == DATA) begin
        rem <= rem - 32'd1;
        wptr <= wptr + {{AW{1'b0}}, ~wptr[AW]};
      end
    end
  always_ff @(posedge clk)
    if (strobe && state == DATA && !wptr[AW]) mem[wptr[AW-1:0]] <= word;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_insn <= NOP_INSN;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= accept;
      if (accept) begin
        fetch_insn <= fault ? NOP_INSN : mem[fetch_addr[AW+1:2]];
        fetch_fault <= fault;
      end
    end
endmodule
